// File: rtl/pool_window_pkg.sv
// pool_window_pkg
//   Shared sizing constants and types for the 2x2 pooling window stage.
//   DWIDTH : pixel width (signed two's complement)
//   MAXW   : maximum feature-map width, also the line-buffer depth
//   SWIDTH : width of the img_w/img_h fields and the row/col counters
//   AWIDTH : line-buffer address width
package pool_window_pkg;

  localparam int DWIDTH = 16;
  localparam int MAXW   = 64;
  localparam int SWIDTH = 7;
  localparam int AWIDTH = $clog2(MAXW);

  typedef logic signed [DWIDTH-1:0] pixel_t;
  typedef logic [SWIDTH-1:0]        size_t;
  typedef logic [AWIDTH-1:0]        addr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Column counter to line-buffer address; col never exceeds MAXW-1.
  function automatic addr_t col_addr(input size_t col);
    return col[AWIDTH-1:0];
  endfunction

endpackage

// File: rtl/pool_window_if.sv
// pool_window_if
//   Groups the frame-control, pixel-stream and window outputs of pool_window.
//   master : drives start/img_w/img_h/valid_in/pixel_in, observes the window side
//   slave  : the pool_window block itself
//   Signals:
//     start, img_w, img_h        frame start pulse and frame dimensions
//     valid_in, pixel_in         raster pixel stream (no backpressure)
//     pixel_feat0..3             current 2x2 window (TL, TR, BL, BR)
//     out_en                     one-cycle capture strobe for the pool stage
//     busy, frame_done           frame status
interface pool_window_if;
  import pool_window_pkg::*;

  logic   start;
  size_t  img_w;
  size_t  img_h;
  logic   valid_in;
  pixel_t pixel_in;

  pixel_t pixel_feat0;
  pixel_t pixel_feat1;
  pixel_t pixel_feat2;
  pixel_t pixel_feat3;
  logic   out_en;
  logic   busy;
  logic   frame_done;

  modport master (
    output start, img_w, img_h, valid_in, pixel_in,
    input  pixel_feat0, pixel_feat1, pixel_feat2, pixel_feat3,
    input  out_en, busy, frame_done
  );

  modport slave (
    input  start, img_w, img_h, valid_in, pixel_in,
    output pixel_feat0, pixel_feat1, pixel_feat2, pixel_feat3,
    output out_en, busy, frame_done
  );

endinterface

// File: rtl/pool_window_line_buffer.sv
// pool_window_line_buffer
//   One-line pixel store (MAXW x DWIDTH). One synchronous write port and two
//   combinational read ports; the reads are sampled by the window registers in
//   the top on the same edge that accepts the odd/odd pixel, so the buffered
//   top-row pair lands on the feature outputs one cycle after that accept.
//   Contents are not reset.
//   Ports:
//     clk              clock
//     we, waddr, wdata write port
//     raddr_a/rdata_a  read port A (window column 2c)
//     raddr_b/rdata_b  read port B (window column 2c+1)
module pool_window_line_buffer
  import pool_window_pkg::*;
(
  input  logic   clk,
  input  logic   we,
  input  addr_t  waddr,
  input  pixel_t wdata,
  input  addr_t  raddr_a,
  input  addr_t  raddr_b,
  output pixel_t rdata_a,
  output pixel_t rdata_b
);

  pixel_t mem [MAXW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/pool_window.sv
// pool_window
//   Turns a raster-order feature map into non-overlapping 2x2 windows (stride 2)
//   for the downstream max-pool stage. Even rows are stored in a one-line
//   buffer; when the bottom-right pixel of a window (odd row, odd col) is
//   accepted, the four window pixels are registered onto pixel_feat0..3 and
//   out_en pulses one cycle later, when pool has registered them.
//   Trailing odd column/row pixels are counted but never windowed.
//
//   state | meaning
//   IDLE  | waiting for start; valid_in ignored
//   RUN   | counting accepted pixels in raster order
//   FLUSH | two cycles draining the strobe pipe; frame_done in the second
//
//   Ports:
//     clk   clock, rising edge
//     xrst  asynchronous active-high reset
//     bus   pool_window_if slave modport (stream in, window out, status)
module pool_window
  import pool_window_pkg::*;
(
  input logic         clk,
  input logic         xrst,
  pool_window_if.slave bus
);

  state_t state;
  size_t  w_lat;
  size_t  h_lat;
  size_t  row;
  size_t  col;
  logic   flush_cnt;
  pixel_t held;
  logic   win_p1;

  pixel_t feat0_q;
  pixel_t feat1_q;
  pixel_t feat2_q;
  pixel_t feat3_q;
  logic   out_en_q;
  logic   busy_q;
  logic   done_q;

  logic   accept;
  logic   last_col;
  logic   last_row;
  logic   at_window;
  logic   buf_we;
  pixel_t rd_left;
  pixel_t rd_right;

  assign accept    = (state == ST_RUN) && bus.valid_in;
  assign last_col  = (col == w_lat - size_t'(1));
  assign last_row  = (row == h_lat - size_t'(1));
  // Odd row and odd column: this pixel closes a 2x2 window.
  assign at_window = accept && row[0] && col[0];
  assign buf_we    = accept && !row[0];

  pool_window_line_buffer u_line_buffer (
    .clk     (clk),
    .we      (buf_we),
    .waddr   (col_addr(col)),
    .wdata   (bus.pixel_in),
    .raddr_a (col_addr(col - size_t'(1))),
    .raddr_b (col_addr(col)),
    .rdata_a (rd_left),
    .rdata_b (rd_right)
  );

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state     <= ST_IDLE;
      w_lat     <= '0;
      h_lat     <= '0;
      row       <= '0;
      col       <= '0;
      flush_cnt <= 1'b0;
      held      <= '0;
      win_p1    <= 1'b0;
      feat0_q   <= '0;
      feat1_q   <= '0;
      feat2_q   <= '0;
      feat3_q   <= '0;
      out_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Two-stage strobe: feats register at T+1, pool captures at T+2.
      win_p1   <= at_window;
      out_en_q <= win_p1;
      done_q   <= 1'b0;

      if (accept) begin
        held <= bus.pixel_in;
      end

      if (at_window) begin
        feat0_q <= rd_left;
        feat1_q <= rd_right;
        feat2_q <= held;
        feat3_q <= bus.pixel_in;
      end

      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state  <= ST_RUN;
            w_lat  <= bus.img_w;
            h_lat  <= bus.img_h;
            row    <= '0;
            col    <= '0;
            busy_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.valid_in) begin
            if (last_col) begin
              col <= '0;
              if (last_row) begin
                state     <= ST_FLUSH;
                flush_cnt <= 1'b0;
              end else begin
                row <= row + size_t'(1);
              end
            end else begin
              col <= col + size_t'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (!flush_cnt) begin
            flush_cnt <= 1'b1;
            done_q    <= 1'b1;
          end else begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pixel_feat0 = feat0_q;
  assign bus.pixel_feat1 = feat1_q;
  assign bus.pixel_feat2 = feat2_q;
  assign bus.pixel_feat3 = feat3_q;
  assign bus.out_en      = out_en_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;

endmodule
